imem_loader: RTL

- Write-side counterpart to the instruction-fetch path.
- Accepts a byte stream from a host link (UART/debug bridge) and packs each 4 bytes into a 32-bit word.
- Writes words to sequential addresses of the instruction BRAM's write port, starting at address 0.
- The processor's fetch logic reads the same memory once `done` is asserted.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_byte_packer.sv | 53 +++++
 rtl/imem_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory load path and the fetch path.
package imem_loader_pkg;

  // Instruction BRAM geometry, shared with the fetch logic.
  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_DEPTH  = 4096;

  // Bytes packed into one instruction word.
  localparam int BYTES_PER_WORD = 4;

  // Loader FSM encoding.
  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word lands in [31:24].
// The counter tracks bytes of the current word; 'full' marks a complete word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full,
  output logic        last
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_cnt;
  logic        r_full;
  logic [31:0] r_shift;

  // 'last' flags the transfer that completes the word, so the FSM can
  // move to WRITE on the same edge that captures the final byte.
  assign last = shift_en && (r_cnt == LAST_IDX);
  assign word = r_shift;
  assign full = r_full;

  // Byte counter and word-complete flag; clear wins over a shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_full <= 1'b0;
    end else if (clear) begin
      r_cnt  <= 2'd0;
      r_full <= 1'b0;
    end else if (shift_en) begin
      r_cnt <= r_cnt + 2'd1;
      if (r_cnt == LAST_IDX) begin
        r_full <= 1'b1;
      end
    end
  end

  // Shift register: older bytes move toward the MSB as new ones arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= 32'd0;
    end else if (shift_en) begin
      r_shift <= {r_shift[23:0], byte_in};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a host byte stream into 32-bit words and
// writes them to consecutive BRAM addresses starting at 0. The fetch path may
// use the memory once 'done' is high.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  // Largest legal length: the whole memory (2**ADDR_W words).
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  ld_state_t         r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_word_count;
  logic [ADDR_W-1:0] r_addra;
  logic              r_wea;
  logic              r_byte_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_start_ok;
  logic [ADDR_W:0]   w_len_sat;
  logic [ADDR_W:0]   w_wc_inc;
  logic              w_clear;
  logic              w_shift;
  logic [31:0]       w_word;
  logic              w_full;
  logic              w_last;

  // A start is only honoured when no load is in progress.
  assign w_start_ok = start && ((r_state == LD_IDLE) || (r_state == LD_DONE));

  // Oversized requests are clamped to the memory depth so addra never wraps.
  assign w_len_sat  = (load_len > MAX_LEN) ? MAX_LEN : load_len;

  assign w_wc_inc   = r_word_count + 1'b1;

  // The packer restarts on a new load and after every committed word.
  assign w_clear    = w_start_ok || (r_state == LD_WRITE);
  assign w_shift    = byte_valid && r_byte_ready;

  imem_loader_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .shift_en (w_shift),
    .byte_in  (byte_in),
    .word     (w_word),
    .full     (w_full),
    .last     (w_last)
  );

  assign byte_ready = r_byte_ready;
  assign wea        = r_wea;
  assign addra      = r_addra;
  assign dina       = w_word;
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_count = r_word_count;

  // Loader FSM with registered handshake, write-port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LD_IDLE;
      r_len        <= '0;
      r_word_count <= '0;
      r_addra      <= '0;
      r_wea        <= 1'b0;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_wea <= 1'b0;
      case (r_state)
        LD_IDLE, LD_DONE: begin
          if (start) begin
            r_len        <= w_len_sat;
            r_word_count <= '0;
            r_addra      <= '0;
            if (w_len_sat == '0) begin
              r_state      <= LD_DONE;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_byte_ready <= 1'b0;
            end else begin
              r_state      <= LD_RECV;
              r_done       <= 1'b0;
              r_busy       <= 1'b1;
              r_byte_ready <= 1'b1;
            end
          end
        end

        LD_RECV: begin
          // The edge that takes the 4th byte also schedules the write pulse.
          if (w_last) begin
            r_state      <= LD_WRITE;
            r_byte_ready <= 1'b0;
            r_wea        <= 1'b1;
            r_addra      <= r_word_count[ADDR_W-1:0];
          end
        end

        LD_WRITE: begin
          if (w_full) begin
            r_word_count <= w_wc_inc;
            if (w_wc_inc == r_len) begin
              r_state <= LD_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state      <= LD_RECV;
              r_byte_ready <= 1'b1;
            end
          end else begin
            // Defensive: an incomplete word is never committed; collect again.
            r_state      <= LD_RECV;
            r_byte_ready <= 1'b1;
          end
        end

        default: begin
          r_state      <= LD_IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
